// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline (A) and a long-latency unit (B).
// Also tracks registers with outstanding long-latency writes and flags read hazards and WAW reissues.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid_i,
    input  logic [4:0]  a_addr_i,
    input  logic [31:0] a_data_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [4:0]  b_addr_i,
    input  logic [31:0] b_data_i,
    output logic        b_ready_o,
    input  logic        iss_set_i,
    input  logic [4:0]  iss_addr_i,
    input  logic [4:0]  rd_addr_1_i,
    input  logic [4:0]  rd_addr_2_i,
    output logic        hazard_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pending_o,
    output logic        err_waw_o
);

    // state   | meaning
    // A_PRI   | pipeline has priority, B accumulates denied cycles
    // B_FORCE | B starved for STARVE_MAX cycles, A is held off
    typedef enum logic {
        A_PRI   = 1'b0,
        B_FORCE = 1'b1
    } arb_state_e;

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    arb_state_e  state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        force_b;
    logic        a_xfer, b_xfer;

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] pending_q, pending_d;
    logic        err_waw_q, err_waw_d;
    logic        iss_cleared;

    assign force_b = (state_q == B_FORCE);

    always_comb begin
        a_ready_o = a_valid_i && !force_b;
        b_ready_o = b_valid_i && (!a_valid_i || force_b);
    end

    assign a_xfer = a_valid_i && a_ready_o;
    assign b_xfer = b_valid_i && b_ready_o;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        state_d      = state_q;
        if (!b_valid_i || b_xfer) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < STARVE_MAX_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        case (state_q)
            A_PRI: begin
                if (starve_cnt_d == STARVE_MAX_C) state_d = B_FORCE;
            end
            B_FORCE: begin
                if (b_xfer || !b_valid_i) state_d = A_PRI;
            end
            default: state_d = A_PRI;
        endcase
    end

    // Writes to r0 complete the handshake but never reach the register file.
    always_comb begin
        wr_addr    = a_xfer ? a_addr_i : b_addr_i;
        wr_data    = a_xfer ? a_data_i : b_data_i;
        rf_we_d    = (a_xfer || b_xfer) && (wr_addr != 5'd0);
        rf_waddr_d = rf_we_d ? wr_addr : rf_waddr_q;
        rf_wdata_d = rf_we_d ? wr_data : rf_wdata_q;
    end

    // A new issue wins over a same-cycle return to the same register.
    always_comb begin
        pending_d   = pending_q;
        err_waw_d   = err_waw_q;
        iss_cleared = b_xfer && (b_addr_i == iss_addr_i);
        if (b_xfer) pending_d[b_addr_i] = 1'b0;
        if (iss_set_i && (iss_addr_i != 5'd0)) begin
            if (pending_q[iss_addr_i] && !iss_cleared) err_waw_d = 1'b1;
            pending_d[iss_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= A_PRI;
            starve_cnt_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
            pending_q    <= 32'd0;
            err_waw_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            pending_q    <= pending_d;
            err_waw_q    <= err_waw_d;
        end
    end

    assign hazard_o   = ((rd_addr_1_i != 5'd0) && pending_q[rd_addr_1_i]) ||
                        ((rd_addr_2_i != 5'd0) && pending_q[rd_addr_2_i]);
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign pending_o  = pending_q;
    assign err_waw_o  = err_waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for starvation and reset,
// then randomized traffic checked against a cycle-level model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid, b_valid, iss_set;
    logic [4:0]  a_addr, b_addr, iss_addr, rd1, rd2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, hazard, rf_we, err_waw;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pending;

    regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_valid), .a_addr_i(a_addr), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_addr_i(b_addr), .b_data_i(b_data), .b_ready_o(b_ready),
        .iss_set_i(iss_set), .iss_addr_i(iss_addr),
        .rd_addr_1_i(rd1), .rd_addr_2_i(rd2), .hazard_o(hazard),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pending_o(pending), .err_waw_o(err_waw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        bv; logic [4:0] ba; logic [31:0] bd;
        logic        iss; logic [4:0] ia; logic [4:0] r1; logic [4:0] r2;
        logic        e_ar; logic e_br; logic e_hz; logic e_we;
        logic [4:0]  e_wa; logic [31:0] e_wd; logic [31:0] e_pend; logic e_err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int          m_cnt;
    logic [31:0] m_pend;
    logic        m_err, m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        s_ar, s_br;

    vec_t tab[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic iss, input logic [4:0] ia,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic ear, input logic ebr, input logic ehz, input logic ewe,
                                input logic [4:0] ewa, input logic [31:0] ewd,
                                input logic [31:0] epend, input logic eerr);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.iss = iss; v.ia = ia; v.r1 = r1; v.r2 = r2;
        v.e_ar = ear; v.e_br = ebr; v.e_hz = ehz; v.e_we = ewe;
        v.e_wa = ewa; v.e_wd = ewd; v.e_pend = epend; v.e_err = eerr;
        return v;
    endfunction

    function automatic vec_t traffic(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                     input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                     input logic iss, input logic [4:0] ia);
        return mk(av, aa, ad, bv, ba, bd, iss, ia, 5'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pend = 32'd0; m_err = 1'b0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    endtask

    task automatic drive(input vec_t v);
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        iss_set = v.iss; iss_addr = v.ia; rd1 = v.r1; rd2 = v.r2;
    endtask

    // One clock cycle: called at posedge+1, checks combinational outputs mid-cycle, registered ones after the edge.
    task automatic cyc(input vec_t v, input bit use_tab);
        logic fb, ear, ebr, ehz;
        logic [4:0] wa;
        drive(v);
        #2;
        fb  = (m_cnt >= SM);
        ear = v.av && !fb;
        ebr = v.bv && (!v.av || fb);
        ehz = ((v.r1 != 0) && m_pend[v.r1]) || ((v.r2 != 0) && m_pend[v.r2]);
        s_ar = a_ready; s_br = b_ready;
        chk("a_ready", 32'(a_ready), 32'(ear));
        chk("b_ready", 32'(b_ready), 32'(ebr));
        chk("hazard", 32'(hazard), 32'(ehz));
        if (use_tab) begin
            chk("tab_a_ready", 32'(a_ready), 32'(v.e_ar));
            chk("tab_b_ready", 32'(b_ready), 32'(v.e_br));
            chk("tab_hazard", 32'(hazard), 32'(v.e_hz));
        end
        if (ebr || !v.bv) m_cnt = 0;
        else if (m_cnt < SM) m_cnt++;
        wa = ear ? v.aa : v.ba;
        if ((ear || ebr) && wa != 0) begin
            m_we = 1'b1; m_wa = wa; m_wd = ear ? v.ad : v.bd;
        end else begin
            m_we = 1'b0;
        end
        if (v.iss && v.ia != 0 && m_pend[v.ia] && !(ebr && v.ba == v.ia)) m_err = 1'b1;
        if (ebr) m_pend[v.ba] = 1'b0;
        if (v.iss && v.ia != 0) m_pend[v.ia] = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_wa));
        chk("rf_wdata", rf_wdata, m_wd);
        chk("pending", pending, m_pend);
        chk("err_waw", 32'(err_waw), 32'(m_err));
        if (use_tab) begin
            chk("tab_rf_we", 32'(rf_we), 32'(v.e_we));
            chk("tab_rf_waddr", 32'(rf_waddr), 32'(v.e_wa));
            chk("tab_rf_wdata", rf_wdata, v.e_wd);
            chk("tab_pending", pending, v.e_pend);
            chk("tab_err_waw", 32'(err_waw), 32'(v.e_err));
        end
    endtask

    initial begin
        vec_t v;
        drive(traffic(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0));
        model_reset();

        //        av aa  ad            bv ba  bd            iss ia  r1 r2  ar br hz we wa  wd            pend        err
        tab[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  0, 0,  1, 0, 0, 1, 5, 32'hDEADBEEF, 32'h0,      0);
        tab[1]  = mk(1, 0, 32'h12345678, 0, 0, 32'h0,        0, 0,  0, 0,  1, 0, 0, 0, 5, 32'hDEADBEEF, 32'h0,      0);
        tab[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0,  0, 0,  0, 0, 0, 0, 5, 32'hDEADBEEF, 32'h0,      0);
        tab[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  0, 0,  0, 0, 0, 0, 5, 32'hDEADBEEF, 32'h80,     0);
        tab[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0,  0, 0, 1, 0, 5, 32'hDEADBEEF, 32'h80,     0);
        tab[5]  = mk(0, 0, 32'h0,        1, 7, 32'hCAFE0007, 0, 0,  7, 0,  0, 1, 1, 1, 7, 32'hCAFE0007, 32'h0,      0);
        tab[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  7, 0,  0, 0, 0, 0, 7, 32'hCAFE0007, 32'h0,      0);
        tab[7]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3,  0, 0,  0, 0, 0, 0, 7, 32'hCAFE0007, 32'h8,      0);
        tab[8]  = mk(0, 0, 32'h0,        1, 3, 32'h33,       1, 3,  0, 0,  0, 1, 0, 1, 3, 32'h33,       32'h8,      0);
        tab[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 3,  0, 3,  0, 0, 1, 0, 3, 32'h33,       32'h8,      1);
        tab[10] = mk(1, 2, 32'hA2,       1, 3, 32'hB3,       0, 0,  0, 0,  1, 0, 0, 1, 2, 32'hA2,       32'h8,      1);
        tab[11] = mk(0, 0, 32'h0,        1, 3, 32'hB3,       0, 0,  0, 0,  0, 1, 0, 1, 3, 32'hB3,       32'h0,      1);

        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_err_waw", 32'(err_waw), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) cyc(tab[i], 1'b1);

        // Starvation: B denied exactly SM cycles, then forced through for one cycle.
        cyc(traffic(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9), 1'b0);
        for (int i = 0; i <= SM; i++) begin
            cyc(traffic(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'd9, 32'h99, 1'b0, 5'd0), 1'b0);
            chk("starve_b_ready", 32'(s_br), (i == SM) ? 32'd1 : 32'd0);
            chk("starve_a_ready", 32'(s_ar), (i == SM) ? 32'd0 : 32'd1);
        end
        chk("starve_pending9", 32'(pending[9]), 32'd0);
        chk("starve_rf_waddr", 32'(rf_waddr), 32'd9);
        cyc(traffic(1'b1, 5'd1, 32'h5, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0), 1'b0);
        chk("force_one_cycle", 32'(s_br), 32'd0);

        // Reset mid-stream with pending 0x480 and starvation count 3.
        cyc(traffic(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7), 1'b0);
        cyc(traffic(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10), 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(traffic(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0), 1'b0);
        chk("pre_rst_pending", pending, 32'h480);
        drive(traffic(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0));
        rst_n = 1'b0;
        #1;
        chk("midrst_rf_we", 32'(rf_we), 32'd0);
        chk("midrst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("midrst_rf_wdata", rf_wdata, 32'd0);
        chk("midrst_pending", pending, 32'd0);
        chk("midrst_a_ready", 32'(a_ready), 32'd1);
        chk("midrst_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(traffic(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0));
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i <= SM; i++) begin
            cyc(traffic(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd4, 32'h44, 1'b0, 5'd0), 1'b0);
            chk("postrst_b_ready", 32'(s_br), (i == SM) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the model; small address range forces collisions.
        for (int i = 0; i < 600; i++) begin
            v = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 4) < 3, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
            cyc(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: max consecutive cycles port B may be denied while valid (range 1..15).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  pipeline write-back request valid.
REQ-005 a_addr  input  5  pipeline destination register.
REQ-006 a_data  input  32  pipeline write data.
REQ-007 a_ready  output  1  pipeline request granted this cycle (combinational).
REQ-008 b_valid  input  1  long-latency unit (mul/div, load-miss return) request valid.
REQ-009 b_addr  input  5  long-latency destination register.
REQ-010 b_data  input  32  long-latency write data.
REQ-011 b_ready  output  1  long-latency request granted this cycle (combinational).
REQ-012 iss_set  input  1  pulse: long-latency op issued; mark iss_addr pending.
REQ-013 iss_addr  input  5  destination of issued long-latency op.
REQ-014 rd_addr_1, rd_addr_2  input  5 each  decode-stage source registers.
REQ-015 hazard  output  1  a source register is pending (combinational).
REQ-016 rf_we  output  1  register-file write enable (registered).
REQ-017 rf_waddr  output  5  register-file write address (registered).
REQ-018 rf_wdata  output  32  register-file write data (registered).
REQ-019 pending  output  32  scoreboard vector, bit n = register n pending.
REQ-020 err_waw  output  1  sticky: iss_set hit an already-pending register.

Function
REQ-021 Single write port shared; at most one grant per cycle; a transfer occurs when valid && ready on a port.
REQ-022 Default priority: A; a_ready = a_valid && !force_b; b_ready = b_valid && (!a_valid || force_b).
REQ-023 starve_cnt (4-bit): increments when b_valid && !b_ready; clears on B transfer or when b_valid = 0; saturates at STARVE_MAX.
REQ-024 force_b = (starve_cnt == STARVE_MAX); while force_b, A is denied regardless of a_valid.
REQ-025 Arbiter states: A_PRI (force_b = 0) and B_FORCE (force_b = 1); A_PRI -> B_FORCE when count reaches STARVE_MAX; B_FORCE -> A_PRI on B transfer or b_valid drop.
REQ-026 Write latency: granted request appears on rf_we/rf_waddr/rf_wdata on the next rising edge; rf_we = 0 in cycles with no transfer.
REQ-027 Address 0: handshake completes normally but rf_we SHALL be 0; pending[0] is never set.
REQ-028 rf_waddr/rf_wdata hold last written values when rf_we = 0.
REQ-029 pending[iss_addr] set at clock edge when iss_set && iss_addr != 0.
REQ-030 pending[b_addr] cleared at clock edge of a B transfer.
REQ-031 Same-cycle iss_set and B transfer to same address: set wins (bit remains 1).
REQ-032 iss_set to an already-pending address (not simultaneously cleared): err_waw set, held until reset; pending unchanged.
REQ-033 hazard = (rd_addr_1 != 0 && pending[rd_addr_1]) || (rd_addr_2 != 0 && pending[rd_addr_2]), evaluated on current-cycle pending.
REQ-034 A transfers do not modify pending.

Reset
REQ-035 While rst_n = 0: rf_we = 0, rf_waddr = 0, rf_wdata = 0, pending = 0, err_waw = 0, starve_cnt = 0, state A_PRI; a_ready/b_ready follow REQ-022 with force_b = 0.
REQ-036 Reset asserted mid-operation discards all in-flight grants and scoreboard state; first write after release needs a new handshake.

Verification
REQ-037 a_valid=1 addr=5 data=0xDEADBEEF, b_valid=0 -> a_ready=1; next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-038 a_valid held 1, b_valid held 1 addr=9, STARVE_MAX=4 -> b_ready=0 for 4 cycles, 5th cycle b_ready=1, a_ready=0; pending[9] cleared after that edge.
REQ-039 iss_set addr=7, then rd_addr_1=7 -> hazard=1 until B transfer addr=7; hazard=0 the cycle after.
REQ-040 iss_set addr=3 twice without B return -> err_waw=1 sticky; same-cycle iss_set addr=3 with B transfer addr=3 -> pending[3] stays 1, err_waw unaffected.
REQ-041 a_valid=1 addr=0 -> a_ready=1, rf_we=0 next cycle; iss_set addr=0 -> pending stays 0.
REQ-042 rst_n low mid-stream with pending=0x00000480, starve_cnt=3 -> outputs zero immediately; after release, B requires 4 fresh denied cycles before forcing.
